// File: rtl/pec_package.sv
// Shared types for the PEC command sequencer: operation and controller state encodings,
// sequencer FSM states and the queued command descriptor.
package pec_package;

  localparam int SEG_ROW = 16;
  localparam int SEG_COL = 8;
  localparam int WL_W    = $clog2(SEG_ROW);
  localparam int BL_W    = $clog2(SEG_COL);
  localparam int COL_W   = 4;
  localparam int REP_W   = 4;

  typedef enum logic [1:0] {
    OP_CLEAR      = 2'd0,
    OP_LD_WEIGHTS = 2'd1,
    OP_LD_BIAS    = 2'd2,
    OP_COMPUTE    = 2'd3
  } pec_operations_e;

  typedef enum logic [2:0] {
    CTRL_READY       = 3'd0,
    CTRL_BUSY        = 3'd1,
    CTRL_FETCH       = 3'd2,
    CTRL_PROGRAMMING = 3'd3,
    CTRL_COMPUTE     = 3'd4,
    CTRL_STORE       = 3'd5
  } pec_ctrl_state_e;

  typedef struct packed {
    pec_ctrl_state_e curr_state;
    pec_ctrl_state_e next_state;
  } pec_ctrl_fsm_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_ACK   = 2'd2,
    SEQ_DONE  = 2'd3
  } pec_seq_state_e;

  typedef struct packed {
    pec_operations_e    op;
    logic [WL_W-1:0]    wl;
    logic [BL_W-1:0]    bl;
    logic [COL_W-1:0]   col;
    logic [REP_W-1:0]   rep;
  } pec_seq_cmd_t;

endpackage

// File: rtl/pec_cmd_fifo.sv
// Synchronous FIFO of command descriptors with flush; occupancy is registered so full/level
// reflect only completed pushes and pops.
module pec_cmd_fifo
  import pec_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  pec_seq_cmd_t             wdata,
  output pec_seq_cmd_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  pec_seq_cmd_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // Flush dominates: a push or pop in the flush cycle is dropped.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pec_cmd_sequencer.sv
// Queues PEC operation descriptors and issues them one at a time to the controller, handling
// repeats, ack timeout and flush. Optional busy-cycle counter under PEC_SEQ_PERF_CNT_EN.
module pec_cmd_sequencer
  import pec_package::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_TMO    = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  pec_operations_e               cmd_op_i,
  input  logic [WL_W-1:0]               cmd_wl_i,
  input  logic [BL_W-1:0]               cmd_bl_i,
  input  logic [COL_W-1:0]              cmd_col_i,
  input  logic [REP_W-1:0]              cmd_rep_i,
  input  logic                          flush_i,
  input  pec_ctrl_fsm_state_t           ctrl_state_i,
  output logic                          start_o,
  output pec_operations_e               op_o,
  output logic [WL_W-1:0]               wl_o,
  output logic [BL_W-1:0]               bl_o,
  output logic [COL_W-1:0]              col_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_tmo_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [31:0]                   perf_busy_o
);

  localparam int TW = $clog2(ACK_TMO + 1);

  pec_seq_state_e   state_q, state_d;
  pec_seq_cmd_t     push_cmd, head_cmd;
  logic             fifo_full, fifo_empty;
  logic             pop, tmo_hit, rep_step, ctrl_ready;
  logic [REP_W-1:0] rep_cnt_q;
  logic [TW-1:0]    tmr_q;
  logic             ctrl_next_unused;

  assign ctrl_ready       = (ctrl_state_i.curr_state == CTRL_READY);
  assign ctrl_next_unused = ^ctrl_state_i.next_state;
  assign push_cmd         = '{op: cmd_op_i, wl: cmd_wl_i, bl: cmd_bl_i, col: cmd_col_i, rep: cmd_rep_i};
  assign cmd_ready_o      = ~fifo_full;
  assign busy_o           = (level_o != '0) | (state_q != SEQ_IDLE);

  pec_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (cmd_valid_i),
    .pop   (pop),
    .flush (flush_i),
    .wdata (push_cmd),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEQ_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:  if (pop) state_d = SEQ_ISSUE;
      SEQ_ISSUE: state_d = SEQ_ACK;
      SEQ_ACK: begin
        if (!ctrl_ready)  state_d = SEQ_DONE;
        else if (tmo_hit) state_d = SEQ_IDLE;
      end
      SEQ_DONE: begin
        if (ctrl_ready) state_d = (rep_cnt_q == '0) ? SEQ_IDLE : SEQ_ISSUE;
      end
      default:   state_d = SEQ_IDLE;
    endcase
  end

  // A flush in the same cycle wins over popping a new head.
  always_comb begin
    start_o  = 1'b0;
    done_o   = 1'b0;
    pop      = 1'b0;
    tmo_hit  = 1'b0;
    rep_step = 1'b0;
    case (state_q)
      SEQ_IDLE:  pop = ~fifo_empty & ctrl_ready & ~flush_i;
      SEQ_ISSUE: start_o = 1'b1;
      SEQ_ACK:   tmo_hit = ctrl_ready & (tmr_q == TW'(ACK_TMO - 1));
      SEQ_DONE: begin
        done_o   = ctrl_ready & (rep_cnt_q == '0);
        rep_step = ctrl_ready & (rep_cnt_q != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_o      <= OP_CLEAR;
      wl_o      <= '0;
      bl_o      <= '0;
      col_o     <= '0;
      rep_cnt_q <= '0;
      tmr_q     <= '0;
      err_tmo_o <= 1'b0;
    end else begin
      if (pop) begin
        op_o      <= head_cmd.op;
        wl_o      <= head_cmd.wl;
        bl_o      <= head_cmd.bl;
        col_o     <= head_cmd.col;
        rep_cnt_q <= head_cmd.rep;
      end else if (rep_step) begin
        rep_cnt_q <= rep_cnt_q - 1'b1;
        bl_o      <= bl_o + BL_W'(4);
        col_o     <= col_o + 1'b1;
      end
      if (state_q == SEQ_ISSUE)    tmr_q <= '0;
      else if (state_q == SEQ_ACK) tmr_q <= tmr_q + 1'b1;
      if (tmo_hit)      err_tmo_o <= 1'b1;
      else if (flush_i) err_tmo_o <= 1'b0;
    end
  end

`ifdef PEC_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       perf_q <= '0;
    else if (busy_o && perf_q != '1)   perf_q <= perf_q + 1'b1;
  end

  assign perf_busy_o = perf_q;
`else
  assign perf_busy_o = '0;
`endif

endmodule

// File: tb/tb_pec_cmd_sequencer.sv
// Directed self-checking bench for pec_cmd_sequencer with a small reactive controller model.
// Perf counter checks follow PEC_SEQ_PERF_CNT_EN.
module tb_pec_cmd_sequencer;
  import pec_package::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  pec_operations_e      cmd_op_i;
  logic [WL_W-1:0]      cmd_wl_i;
  logic [BL_W-1:0]      cmd_bl_i;
  logic [COL_W-1:0]     cmd_col_i;
  logic [REP_W-1:0]     cmd_rep_i;
  logic                 flush_i;
  pec_ctrl_fsm_state_t  ctrl_state_i = '{curr_state: CTRL_READY, next_state: CTRL_READY};
  logic                 start_o;
  pec_operations_e      op_o;
  logic [WL_W-1:0]      wl_o;
  logic [BL_W-1:0]      bl_o;
  logic [COL_W-1:0]     col_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_tmo_o;
  logic [2:0]           level_o;
  logic [31:0]          perf_busy_o;

  int test_count = 0;
  int fail_count = 0;
  int ctrl_mode  = 0;
  int busy_len   = 2;
  int done_total = 0;
  int busy_cycles = 0;
  logic [12:0] start_log[$];

  pec_cmd_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_wl_i(cmd_wl_i), .cmd_bl_i(cmd_bl_i), .cmd_col_i(cmd_col_i),
    .cmd_rep_i(cmd_rep_i), .flush_i(flush_i), .ctrl_state_i(ctrl_state_i), .start_o(start_o),
    .op_o(op_o), .wl_o(wl_o), .bl_o(bl_o), .col_o(col_o), .busy_o(busy_o), .done_o(done_o),
    .err_tmo_o(err_tmo_o), .level_o(level_o), .perf_busy_o(perf_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Controller model: mode 0 reacts to start with busy_len not-ready cycles, 1 holds BUSY, 2 holds READY.
  always begin : ctrl_model
    pec_ctrl_state_e curr;
    int busy_left;
    curr = CTRL_READY;
    busy_left = 0;
    forever begin
      @(posedge clk_i);
      #2;
      if (ctrl_mode == 1) begin
        curr = CTRL_BUSY;
        busy_left = 0;
      end else if (ctrl_mode == 2) begin
        curr = CTRL_READY;
        busy_left = 0;
      end else if (start_o) begin
        curr = CTRL_BUSY;
        busy_left = busy_len;
      end else if (busy_left > 1) begin
        busy_left--;
      end else begin
        busy_left = 0;
        curr = CTRL_READY;
      end
      ctrl_state_i = '{curr_state: curr, next_state: curr};
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (start_o) start_log.push_back({op_o, wl_o, bl_o, col_o});
      if (done_o)  done_total++;
      if (busy_o)  busy_cycles++;
    end
  end

  function automatic logic [12:0] entry(pec_operations_e op, logic [WL_W-1:0] wl,
                                        logic [BL_W-1:0] bl, logic [COL_W-1:0] col);
    return {op, wl, bl, col};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkEntry(input string tag, input int idx, input logic [12:0] expected);
    logic [12:0] actual;
    actual = (idx < start_log.size()) ? start_log[idx] : 13'h1fff;
    checkOutput(tag, 32'(actual), 32'(expected));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input pec_operations_e op, input logic [WL_W-1:0] wl,
                               input logic [BL_W-1:0] bl, input logic [COL_W-1:0] col,
                               input logic [REP_W-1:0] rep);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_wl_i    = wl;
    cmd_bl_i    = bl;
    cmd_col_i   = col;
    cmd_rep_i   = rep;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (!busy_o && ctrl_state_i.curr_state == CTRL_READY) break;
    end
    checkOutput(tag, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int s_base;
    int d_base;
    int b_base;
    logic found;
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_op_i = OP_CLEAR;
    cmd_wl_i = '0;
    cmd_bl_i = '0;
    cmd_col_i = '0;
    cmd_rep_i = '0;
    flush_i = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;

    checkOutput("rst_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("rst_level", 32'(level_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_err", 32'(err_tmo_o), 32'd0);
    checkOutput("rst_start", 32'(start_o), 32'd0);
    checkOutput("rst_fields", 32'({op_o, wl_o, bl_o, col_o}), 32'd0);
    checkOutput("rst_perf", perf_busy_o, 32'd0);

    // Single command with latency check
    s_base = start_log.size();
    d_base = done_total;
    applyStimulus(OP_LD_BIAS, 4'd2, 3'd1, 4'd0, 4'd0);
    checkOutput("t1_level", 32'(level_o), 32'd1);
    step();
    checkOutput("t1_start_latency", 32'(start_o), 32'd1);
    step();
    checkOutput("t1_start_pulse", 32'(start_o), 32'd0);
    waitIdle("t1_idle", 40);
    checkOutput("t1_starts", 32'(start_log.size() - s_base), 32'd1);
    checkEntry("t1_entry", s_base, entry(OP_LD_BIAS, 4'd2, 3'd1, 4'd0));
    checkOutput("t1_done", 32'(done_total - d_base), 32'd1);
    checkOutput("t1_hold", 32'({op_o, wl_o, bl_o}), 32'({OP_LD_BIAS, 4'd2, 3'd1}));

    // Fill FIFO while controller busy
    ctrl_mode = 1;
    step();
    s_base = start_log.size();
    d_base = done_total;
    applyStimulus(OP_COMPUTE,    4'd1, 3'd0, 4'd1, 4'd0);
    applyStimulus(OP_LD_WEIGHTS, 4'd3, 3'd2, 4'd2, 4'd0);
    applyStimulus(OP_CLEAR,      4'd5, 3'd3, 4'd3, 4'd0);
    applyStimulus(OP_LD_BIAS,    4'd7, 3'd5, 4'd4, 4'd0);
    checkOutput("t2_full_ready", 32'(cmd_ready_o), 32'd0);
    checkOutput("t2_full_level", 32'(level_o), 32'd4);
    applyStimulus(OP_COMPUTE, 4'd9, 3'd6, 4'd6, 4'd0);
    checkOutput("t2_reject_level", 32'(level_o), 32'd4);
    ctrl_mode = 0;
    waitIdle("t2_idle", 200);
    checkOutput("t2_starts", 32'(start_log.size() - s_base), 32'd4);
    checkEntry("t2_entry0", s_base + 0, entry(OP_COMPUTE,    4'd1, 3'd0, 4'd1));
    checkEntry("t2_entry1", s_base + 1, entry(OP_LD_WEIGHTS, 4'd3, 3'd2, 4'd2));
    checkEntry("t2_entry2", s_base + 2, entry(OP_CLEAR,      4'd5, 3'd3, 4'd3));
    checkEntry("t2_entry3", s_base + 3, entry(OP_LD_BIAS,    4'd7, 3'd5, 4'd4));
    checkOutput("t2_done", 32'(done_total - d_base), 32'd4);

    // Repeats with bl/col wrap
    s_base = start_log.size();
    d_base = done_total;
    applyStimulus(OP_LD_WEIGHTS, 4'd4, 3'd0, 4'd14, 4'd2);
    waitIdle("t3_idle", 80);
    checkOutput("t3_starts", 32'(start_log.size() - s_base), 32'd3);
    checkEntry("t3_rep0", s_base + 0, entry(OP_LD_WEIGHTS, 4'd4, 3'd0, 4'd14));
    checkEntry("t3_rep1", s_base + 1, entry(OP_LD_WEIGHTS, 4'd4, 3'd4, 4'd15));
    checkEntry("t3_rep2", s_base + 2, entry(OP_LD_WEIGHTS, 4'd4, 3'd0, 4'd0));
    checkOutput("t3_done", 32'(done_total - d_base), 32'd1);

    // Ack timeout, then recovery
    ctrl_mode = 2;
    s_base = start_log.size();
    d_base = done_total;
    applyStimulus(OP_COMPUTE, 4'd6, 3'd2, 4'd5, 4'd0);
    for (int i = 0; i < 40 && !err_tmo_o; i++) step();
    checkOutput("t4_err", 32'(err_tmo_o), 32'd1);
    step();
    checkOutput("t4_no_done", 32'(done_total - d_base), 32'd0);
    checkOutput("t4_idle_busy", 32'(busy_o), 32'd0);
    ctrl_mode = 0;
    applyStimulus(OP_LD_BIAS, 4'd8, 3'd7, 4'd9, 4'd0);
    waitIdle("t4_idle", 40);
    checkOutput("t4_starts", 32'(start_log.size() - s_base), 32'd2);
    checkEntry("t4_entry1", s_base + 1, entry(OP_LD_BIAS, 4'd8, 3'd7, 4'd9));
    checkOutput("t4_done", 32'(done_total - d_base), 32'd1);
    checkOutput("t4_err_sticky", 32'(err_tmo_o), 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checkOutput("t4_err_cleared", 32'(err_tmo_o), 32'd0);

    // Flush with one in flight and three queued; coincident push dropped
    busy_len = 6;
    s_base = start_log.size();
    d_base = done_total;
    applyStimulus(OP_COMPUTE,    4'd10, 3'd6, 4'd15, 4'd1);
    applyStimulus(OP_LD_BIAS,    4'd11, 3'd1, 4'd1,  4'd0);
    applyStimulus(OP_CLEAR,      4'd12, 3'd2, 4'd2,  4'd0);
    applyStimulus(OP_LD_WEIGHTS, 4'd13, 3'd3, 4'd3,  4'd0);
    checkOutput("t5_level_pre", 32'(level_o), 32'd3);
    flush_i = 1'b1;
    applyStimulus(OP_COMPUTE, 4'd14, 3'd4, 4'd4, 4'd0);
    flush_i = 1'b0;
    checkOutput("t5_level_flush", 32'(level_o), 32'd0);
    checkOutput("t5_ready_flush", 32'(cmd_ready_o), 32'd1);
    waitIdle("t5_idle", 100);
    repeat (5) step();
    checkOutput("t5_starts", 32'(start_log.size() - s_base), 32'd2);
    checkEntry("t5_rep0", s_base + 0, entry(OP_COMPUTE, 4'd10, 3'd6, 4'd15));
    checkEntry("t5_rep1", s_base + 1, entry(OP_COMPUTE, 4'd10, 3'd2, 4'd0));
    checkOutput("t5_done", 32'(done_total - d_base), 32'd1);

    // Reset while waiting in SEQ_DONE
    applyStimulus(OP_LD_BIAS, 4'd1, 3'd3, 4'd2, 4'd3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = start_o;
    end
    checkOutput("t6_start_seen", 32'(found), 32'd1);
    step();
    step();
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("t6_rst_done", 32'(done_o), 32'd0);
    checkOutput("t6_rst_fields", 32'({op_o, wl_o, bl_o, col_o}), 32'd0);
    checkOutput("t6_rst_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("t6_rst_perf", perf_busy_o, 32'd0);
    step();
    rst_ni = 1'b1;
    s_base = start_log.size();
    b_base = busy_cycles;
    repeat (20) step();
    checkOutput("t6_no_start", 32'(start_log.size() - s_base), 32'd0);
    checkOutput("t6_idle_busy", 32'(busy_o), 32'd0);
    busy_len = 2;
    applyStimulus(OP_COMPUTE, 4'd3, 3'd1, 4'd7, 4'd0);
    waitIdle("t6_idle", 40);
`ifdef PEC_SEQ_PERF_CNT_EN
    checkOutput("t6_perf", perf_busy_o, 32'(busy_cycles - b_base));
`else
    checkOutput("t6_perf_tied", perf_busy_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
